// File: rtl/core_launcher.sv
// core_launcher: host-side run controller for the 9-bit-ISA core.
// Streams a payload into data memory, releases the core from reset,
// waits for core_done (with a timeout), then streams a fixed result
// window back out. The launcher owns the memory port except in RUN.
module core_launcher #(
  parameter logic [7:0]  RES_BASE = 8'd64,
  parameter int          RES_LEN  = 8,
  parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  load_len,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        mem_own,
  output logic        mem_wr_en,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wr_data,
  input  logic [7:0]  mem_rd_data,
  output logic        core_reset,
  output logic        core_req,
  input  logic        core_done,
  output logic        busy,
  output logic        error,
  output logic        fin,
  output logic [15:0] cycles
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  // Window length needs 9 bits so a full 256-byte window is representable.
  localparam logic [8:0]  RES_LEN_C  = 9'(RES_LEN);
  localparam logic [15:0] TIMEOUT_M1 = TIMEOUT - 16'd1;

  logic [2:0]  state_reg, state_next;
  logic [7:0]  addr_reg, addr_next;
  logic [8:0]  cnt_reg, cnt_next;
  logic [15:0] cycles_reg, cycles_next;
  logic        error_reg, error_next;

  logic in_hs;
  logic out_hs;
  logic last_cnt;

  assign in_hs    = (state_reg == S_LOAD) && in_valid;
  assign out_hs   = (state_reg == S_DRAIN) && out_ready;
  assign last_cnt = (cnt_reg == 9'd1);

  // Next-state and datapath updates for the run sequence.
  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    cnt_next    = cnt_reg;
    cycles_next = cycles_reg;
    error_next  = error_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          cnt_next    = {1'b0, load_len};
          addr_next   = 8'd0;
          cycles_next = 16'd0;
          error_next  = 1'b0;
          state_next  = (load_len != 8'd0) ? S_LOAD : S_LAUNCH;
        end
      end
      S_LOAD: begin
        if (in_hs) begin
          addr_next = addr_reg + 8'd1;
          cnt_next  = cnt_reg - 9'd1;
          if (last_cnt) state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_next = S_RUN;
      end
      S_RUN: begin
        if (core_done) begin
          addr_next  = RES_BASE;
          cnt_next   = RES_LEN_C;
          state_next = S_DRAIN;
        end else if (cycles_reg == TIMEOUT_M1) begin
          // Saturate at TIMEOUT so the host sees exactly how long it ran.
          cycles_next = TIMEOUT;
          error_next  = 1'b1;
          state_next  = S_IDLE;
        end else begin
          cycles_next = cycles_reg + 16'd1;
        end
      end
      S_DRAIN: begin
        // addr only moves on a handshake, which keeps out_data stable
        // while the host stalls.
        if (out_hs) begin
          addr_next = addr_reg + 8'd1;
          cnt_next  = cnt_reg - 9'd1;
          if (last_cnt) state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      addr_reg   <= 8'd0;
      cnt_reg    <= 9'd0;
      cycles_reg <= 16'd0;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      cnt_reg    <= cnt_next;
      cycles_reg <= cycles_next;
      error_reg  <= error_next;
    end
  end

  // Outputs decoded from state; only write strobe and fin see handshakes.
  assign in_ready    = (state_reg == S_LOAD);
  assign out_valid   = (state_reg == S_DRAIN);
  assign mem_own     = (state_reg != S_RUN);
  assign core_reset  = (state_reg != S_RUN);
  assign core_req    = (state_reg == S_RUN);
  assign busy        = (state_reg != S_IDLE);
  assign mem_wr_en   = in_hs;
  assign mem_wr_data = in_data;
  assign mem_addr    = addr_reg;
  assign out_data    = mem_rd_data;
  assign fin         = out_hs && last_cnt;
  assign error       = error_reg;
  assign cycles      = cycles_reg;

endmodule

// File: doc/core_launcher.md
# core_launcher

Host-side run controller sitting directly upstream of the 9-bit-ISA processor core. On a host `start`, it streams a byte payload into data memory and releases the core from reset. It then waits for the core's `done` flag and streams a fixed result window back out of data memory. It owns the data-memory port whenever the core is not running and counts execution cycles, with a timeout.

## Interface
- `RES_BASE`, default 8'd64: first data-memory address of the result window.
- `RES_LEN`, default 8: result window length in bytes (1..256).
- `TIMEOUT`, default 16'hFFFF: maximum RUN cycles before abort (≥2).
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  host start request; sampled only in IDLE.
- `load_len`  in  8  payload byte count, latched on accepted `start`; 0 = no payload.
- `in_data`  in  8  payload byte.
- `in_valid` in 1 / `in_ready` out 1  payload handshake.
- `out_data`  out  8  result byte (combinational from `mem_rd_data`).
- `out_valid` out 1 / `out_ready` in 1  result handshake.
- `mem_own`  out  1  1 = launcher drives the data-memory port, 0 = core drives it.
- `mem_wr_en`  out  1  data-memory write strobe.
- `mem_addr`  out  8  data-memory address.
- `mem_wr_data`  out  8  data-memory write data.
- `mem_rd_data`  in  8  data-memory read data; combinational from `mem_addr`.
- `core_reset`  out  1  active-high reset to the core.
- `core_req`  out  1  request to the core.
- `core_done`  in  1  core completion flag (level).
- `busy`  out  1  high in any state other than IDLE.
- `error`  out  1  sticky timeout flag; cleared on the next accepted `start`.
- `fin`  out  1  one-cycle pulse when the last result byte is accepted.
- `cycles`  out  16  RUN cycle count of the last/current run.

## Operation
- States: IDLE, LOAD, LAUNCH, RUN, DRAIN. The state register uses async reset to IDLE.
- IDLE
  - `start`=1 moves to LOAD if `load_len`≠0, otherwise to LAUNCH.
  - Accepting `start` also sets `cnt`←`load_len`, `addr`←0, `cycles`←0 and `error`←0.
- LOAD
  - `in_ready`=1.
  - On `in_valid&in_ready`: `mem_wr_en`=1, `mem_addr`=`addr`, `mem_wr_data`=`in_data`; then `addr`++ and `cnt`--.
  - The handshake with `cnt`==1 moves to LAUNCH.
- LAUNCH
  - One cycle with `core_reset`=1. Next state is RUN.
- RUN
  - `core_reset`=0, `core_req`=1, `mem_own`=0.
  - `core_done`=1 moves to DRAIN with `addr`←`RES_BASE` and `cnt`←`RES_LEN`; `cycles` is unchanged.
  - Otherwise, if `cycles`==`TIMEOUT`-1: `cycles`←`TIMEOUT`, `error`←1, go to IDLE.
  - Otherwise `cycles`++.
- DRAIN
  - `out_valid`=1, `mem_addr`=`addr`, `out_data`=`mem_rd_data`.
  - On `out_valid&out_ready`: `addr`++ and `cnt`--.
  - The last handshake pulses `fin`=1 and returns to IDLE.
- Output values outside the states listed above:
  - `core_reset`=1 in every state except RUN.
  - `mem_own`=1 in every state except RUN.
  - `mem_wr_en`=0 outside LOAD handshakes.
  - `in_ready`=0 outside LOAD; `out_valid`=0 outside DRAIN.
- Arithmetic: `addr` is 8-bit and wraps 255→0. `cnt` is 9-bit so that `RES_LEN`=256 works. `cycles` never exceeds `TIMEOUT`.
- `start` outside IDLE is ignored.
- `error` stays set through IDLE until the next accepted `start`.

## Timing
- Reset values: state=IDLE, `core_reset`=1, `mem_own`=1, `core_req`=0, `busy`=0, `error`=0, `fin`=0, `cycles`=0, `in_ready`=0, `out_valid`=0, `mem_wr_en`=0.
- `in_ready` and `out_valid` are decoded from the state register and carry no combinational path from `in_valid`/`out_ready`.
- `mem_wr_en` and `mem_wr_data` are combinational within the LOAD handshake cycle.
- Latencies:
  - `start` cycle → `in_ready`=1 the next cycle.
  - Last payload handshake → LAUNCH next cycle → RUN the cycle after.
  - `core_done` sampled high → `out_valid` next cycle.
- `cycles` equals the number of RUN cycles in which `core_done` was 0.
- Under backpressure (`out_valid`=1, `out_ready`=0), `out_data` is held stable because `addr` does not change.
- `core_done` is ignored outside RUN.
- Async reset mid-operation aborts immediately to the reset values. Partial memory contents are left as written.

## Test plan
1. Assert reset mid-LOAD after 2 of 5 bytes → all outputs at reset values, `core_reset`=1. After release, `start` with `load_len`=5 restarts the load at addr 0.
2. `load_len`=3, bytes 0xA1/0xB2/0xC3 with a 2-cycle `in_valid` gap → writes at addr 0/1/2 exactly once each. LAUNCH holds `core_reset`=1 for 1 cycle, then `core_req`=1.
3. `core_done` rises on the 11th RUN cycle → `cycles`=10. DRAIN reads addresses 64..71 with `out_ready` toggling 1010 → 8 bytes in order, data stable while stalled, `fin` pulses once.
4. `TIMEOUT`=20, `core_done` never asserted → after 20 RUN cycles `error`=1, `cycles`=20, IDLE, no `out_valid`. The next `start` clears `error`.
5. `load_len`=0 → IDLE→LAUNCH→RUN with no writes. A `start` pulse during RUN is ignored.
6. `RES_BASE`=252, `RES_LEN`=8 → DRAIN addresses 252,253,254,255,0,1,2,3.
